tcp_rx_segment_parser: RTL

- Sits directly upstream of the TCP reorder buffer, and downstream of the IPv4 RX stage.
- Consumes one TCP segment per AXI4-Stream packet (header + options + payload), one byte per beat.
- Parses and strips the TCP header and filters on the local port. Forwards the payload with its segment sequence number (seq_start), and generates the base_valid/seq_base anchor pulse on SYN.
- Also reports the header fields (ack number, flags, peer window) to the connection state machine.

---
 rtl/tcp_pkg.sv | 45 ++++
 rtl/tcp_hdr_field_shift.sv | 23 ++
 rtl/tcp_rx_segment_parser.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/tcp_pkg.sv
// Shared TCP RX parser definitions: FSM encodings, header offsets, flag bits, captured header layout.
// No logic; latency n/a.
// Backpressure n/a.
package tcp_pkg;

    localparam logic [1:0] S_HDR     = 2'd0;
    localparam logic [1:0] S_OPT     = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_DROP    = 2'd3;

    localparam int TCP_HDR_MIN_BYTES = 20;
    localparam int OFF_DST_PORT      = 2;
    localparam int OFF_SEQ           = 4;
    localparam int OFF_ACK           = 8;
    localparam int OFF_DOFF          = 12;
    localparam int OFF_FLAGS         = 13;
    localparam int OFF_WIN           = 14;
    // Bytes 16-19 (checksum, urgent pointer) are never needed, so capture stops at the window.
    localparam int TCP_CAPTURE_BYTES = 16;

    localparam int FLAG_FIN = 0;
    localparam int FLAG_SYN = 1;
    localparam int FLAG_RST = 2;
    localparam int FLAG_PSH = 3;
    localparam int FLAG_ACK = 4;
    localparam int FLAG_URG = 5;
    localparam int FLAG_ECE = 6;
    localparam int FLAG_CWR = 7;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [3:0]  doff;
        logic [3:0]  rsvd;
        logic [7:0]  flags;
        logic [15:0] window;
    } tcp_hdr_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/tcp_hdr_field_shift.sv
// Big-endian byte capture: each enabled byte shifts in at the LSB end, so byte 0 ends at the MSBs.
// Latency: 1 cycle per byte.
// Backpressure: none; caller gates en with its handshake.
module tcp_hdr_field_shift #(
    parameter int W      = 8,
    parameter int NBYTES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [W-1:0]      din,
    output logic [NBYTES*W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= {q[NBYTES*W-W-1:0], din};
        end
    end

endmodule

// File: rtl/tcp_rx_segment_parser.sv
// Strips the TCP header, filters on local port, forwards payload with seq_start, anchors on SYN.
// Latency: header fields 1 cycle after last header byte; payload is a zero-latency pass-through.
// Backpressure: s_axis_tready follows m_axis_tready in payload, otherwise always ready.
module tcp_rx_segment_parser
    import tcp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SEQ_BITS   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    input  logic [15:0]           local_port,
    output logic [SEQ_BITS-1:0]   seq_start,
    output logic [SEQ_BITS-1:0]   seq_base,
    output logic                  base_valid,
    output logic                  hdr_valid,
    output logic [15:0]           hdr_src_port,
    output logic [SEQ_BITS-1:0]   hdr_ack_num,
    output logic [7:0]            hdr_flags,
    output logic [15:0]           hdr_window,
    output logic                  drop_pulse,
    output logic [15:0]           drop_count
);

    logic [1:0]  state, state_nxt;
    logic [7:0]  byte_cnt, cnt_nxt;
    logic [15:0] lport_q;
    logic [TCP_CAPTURE_BYTES*DATA_WIDTH-1:0] hdr_q;
    tcp_hdr_t    hdr;
    logic        in_fire, cap_en, port_bad, doff_bad, hdr_done, drop_evt, in_payload;
    logic [7:0]  hdr_len_m1;
    logic [SEQ_BITS-1:0] seq_w;
    logic        unused_hdr_bits;

    tcp_hdr_field_shift #(
        .W      (DATA_WIDTH),
        .NBYTES (TCP_CAPTURE_BYTES)
    ) u_capture (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cap_en),
        .din   (s_axis_tdata),
        .q     (hdr_q)
    );

    assign hdr             = hdr_q;
    assign seq_w           = SEQ_BITS'(hdr.seq);
    assign unused_hdr_bits = ^{hdr.dst_port, hdr.rsvd};

    assign in_payload    = rst_n && (state == S_PAYLOAD);
    assign s_axis_tready = rst_n && (in_payload ? m_axis_tready : 1'b1);
    assign m_axis_tvalid = in_payload && s_axis_tvalid;
    assign m_axis_tlast  = in_payload && s_axis_tlast;
    assign m_axis_tdata  = in_payload ? s_axis_tdata : '0;

    assign in_fire    = s_axis_tvalid && s_axis_tready;
    assign cap_en     = in_fire && (state == S_HDR) && (byte_cnt < 8'(TCP_CAPTURE_BYTES));
    // When byte 3 arrives, byte 2 is still sitting in the lowest capture slot.
    assign port_bad   = (byte_cnt == 8'(OFF_DST_PORT + 1)) &&
                        ({hdr_q[7:0], s_axis_tdata} != lport_q);
    assign doff_bad   = (byte_cnt == 8'(OFF_DOFF)) && (s_axis_tdata[7:4] < 4'd5);
    assign hdr_len_m1 = {2'b00, hdr.doff, 2'b00} - 8'd1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = byte_cnt;
        hdr_done  = 1'b0;
        drop_evt  = 1'b0;
        if (in_fire) begin
            case (state)
                S_HDR: begin
                    cnt_nxt = byte_cnt + 8'd1;
                    if (port_bad || doff_bad) begin
                        cnt_nxt = 8'd0;
                        if (s_axis_tlast) drop_evt  = 1'b1;
                        else              state_nxt = S_DROP;
                    end else if ((byte_cnt == 8'(TCP_HDR_MIN_BYTES - 1)) && (hdr.doff == 4'd5)) begin
                        hdr_done  = 1'b1;
                        cnt_nxt   = 8'd0;
                        state_nxt = s_axis_tlast ? S_HDR : S_PAYLOAD;
                    end else if (s_axis_tlast) begin
                        drop_evt = 1'b1;
                        cnt_nxt  = 8'd0;
                    end else if (byte_cnt == 8'(TCP_HDR_MIN_BYTES - 1)) begin
                        state_nxt = S_OPT;
                    end
                end
                S_OPT: begin
                    cnt_nxt = byte_cnt + 8'd1;
                    if (byte_cnt == hdr_len_m1) begin
                        hdr_done  = 1'b1;
                        cnt_nxt   = 8'd0;
                        state_nxt = s_axis_tlast ? S_HDR : S_PAYLOAD;
                    end else if (s_axis_tlast) begin
                        drop_evt  = 1'b1;
                        cnt_nxt   = 8'd0;
                        state_nxt = S_HDR;
                    end
                end
                S_PAYLOAD: begin
                    if (s_axis_tlast) state_nxt = S_HDR;
                end
                default: begin
                    if (s_axis_tlast) begin
                        drop_evt  = 1'b1;
                        state_nxt = S_HDR;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_HDR;
            byte_cnt     <= 8'd0;
            lport_q      <= 16'd0;
            seq_start    <= '0;
            seq_base     <= '0;
            base_valid   <= 1'b0;
            hdr_valid    <= 1'b0;
            hdr_src_port <= 16'd0;
            hdr_ack_num  <= '0;
            hdr_flags    <= 8'd0;
            hdr_window   <= 16'd0;
            drop_pulse   <= 1'b0;
            drop_count   <= 16'd0;
        end else begin
            state      <= state_nxt;
            byte_cnt   <= cnt_nxt;
            hdr_valid  <= hdr_done;
            base_valid <= hdr_done && hdr.flags[FLAG_SYN];
            drop_pulse <= drop_evt;
            if (in_fire && (state == S_HDR) && (byte_cnt == 8'd0)) begin
                lport_q <= local_port;
            end
            if (drop_evt) begin
                drop_count <= sat_inc16(drop_count);
            end
            // A SYN consumes one sequence number, so payload and anchor both start at ISN+1.
            if (hdr_done) begin
                hdr_src_port <= hdr.src_port;
                hdr_ack_num  <= SEQ_BITS'(hdr.ack);
                hdr_flags    <= hdr.flags;
                hdr_window   <= hdr.window;
                seq_start    <= seq_w + SEQ_BITS'(hdr.flags[FLAG_SYN]);
                if (hdr.flags[FLAG_SYN]) begin
                    seq_base <= seq_w + SEQ_BITS'(1);
                end
            end
        end
    end

endmodule
